// File: rtl/bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI3 data-side bridge:
// FSM state encoding, AXI constants and the latched request record.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } bridge_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] LEN_SINGLE = 4'd0;
  localparam logic [2:0] SIZE_BYTE  = 3'b000;
  localparam logic [2:0] SIZE_HALF  = 3'b001;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  // Request fields held for the whole AXI transaction.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  axsize;
    logic [3:0]  wstrb;
  } req_t;

  // SRAM size code to AXI size code; the reserved code 3 behaves as a word.
  function automatic logic [2:0] axsize_of(input logic [1:0] size);
    axsize_of = (size == 2'd3) ? SIZE_WORD : {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Bundle of the CPU-side SRAM-like request port and the AXI3 master port.
// modport master: the bridge (responds to the CPU, masters the AXI bus).
// modport slave : the surrounding environment (CPU pipeline + interconnect).
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high; a valid, once raised, stays high with stable payload until
// its transfer. On the CPU side addr_ok is the ready for req and data_ok is a
// one-cycle completion pulse with no back-pressure.
interface sram_axi_bridge_if;

  // CPU side
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // AXI read address / data
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata_axi;
  logic        rvalid;
  logic        rlast;
  logic        rready;

  // AXI write address / data / response
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata_axi;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata_axi, rvalid, rlast,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata_axi, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata_axi, rvalid, rlast,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata_axi, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );

endinterface

// File: rtl/wstrb_gen.sv
// Byte-lane write strobe from transfer size and low address bits.
module wstrb_gen (
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  // Byte: one lane at addr[1:0]; halfword: lane pair at addr[1]; else all lanes.
  always_comb begin
    wstrb = 4'b1111;
    case (size)
      2'd0:    wstrb = 4'b0001 << addr_lo;
      2'd1:    wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      default: wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// SRAM-like to single-beat AXI3 bridge, one transaction outstanding.
// Optional macro BRIDGE_RDATA_BUF_EN: register read data so data_ok/rdata
// for reads come from flops one cycle after the R handshake. Undefined,
// read completion is combinational from rvalid.
module sram_axi_bridge
  import bridge_pkg::*;
#(
  parameter logic [3:0] BRIDGE_ID = 4'd1
) (
  input  logic          clk,
  input  logic          rst,
  sram_axi_bridge_if.master bus,
  output bridge_state_e dbg_state
);

  bridge_state_e state_q, state_d;
  req_t          req_q, req_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [3:0]    wstrb_in;
  logic          rd_hs;
  logic          b_hs;
  logic          unused_rlast;

  wstrb_gen u_wstrb_gen (
    .size    (bus.size),
    .addr_lo (bus.addr[1:0]),
    .wstrb   (wstrb_in)
  );

  assign rd_hs        = (state_q == ST_RD_DATA) & bus.rvalid;
  assign b_hs         = (state_q == ST_WR_RESP) & bus.bvalid;
  assign unused_rlast = bus.rlast;

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          req_d = '{addr:   bus.addr,
                    wdata:  bus.wdata,
                    axsize: axsize_of(bus.size),
                    wstrb:  wstrb_in};
          if (bus.wr) begin
            state_d   = ST_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = ST_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_RD_ADDR: begin
        if (bus.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (bus.rvalid) begin
          rready_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        // AW and W complete independently; leave once both have transferred.
        if (awvalid_q && bus.awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && bus.wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d   = ST_WR_RESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_WR_RESP: begin
        if (bus.bvalid) begin
          bready_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
    endcase
  end

  // FSM state, latched request and AXI valid/ready flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef BRIDGE_RDATA_BUF_EN
  logic        rd_ok_q, rd_ok_d;
  logic [31:0] rbuf_q, rbuf_d;

  // Capture read data on the R handshake for a registered completion.
  always_comb begin
    rd_ok_d = rd_hs;
    rbuf_d  = rd_hs ? bus.rdata_axi : rbuf_q;
  end

  // Read completion flops; FSM is already back in IDLE when these fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ok_q <= 1'b0;
      rbuf_q  <= '0;
    end else begin
      rd_ok_q <= rd_ok_d;
      rbuf_q  <= rbuf_d;
    end
  end

  assign bus.data_ok = rd_ok_q | b_hs;
  assign bus.rdata   = rbuf_q;
`else
  // Read data flows straight through while the R beat is presented.
  assign bus.data_ok = rd_hs | b_hs;
  assign bus.rdata   = (state_q == ST_RD_DATA) ? bus.rdata_axi : 32'd0;
`endif

  assign bus.addr_ok   = bus.req & (state_q == ST_IDLE);

  assign bus.arid      = BRIDGE_ID;
  assign bus.araddr    = req_q.addr;
  assign bus.arlen     = LEN_SINGLE;
  assign bus.arsize    = req_q.axsize;
  assign bus.arburst   = BURST_INCR;
  assign bus.arvalid   = arvalid_q;
  assign bus.rready    = rready_q;

  assign bus.awid      = BRIDGE_ID;
  assign bus.awaddr    = req_q.addr;
  assign bus.awlen     = LEN_SINGLE;
  assign bus.awsize    = req_q.axsize;
  assign bus.awburst   = BURST_INCR;
  assign bus.awvalid   = awvalid_q;
  assign bus.wid       = BRIDGE_ID;
  assign bus.wdata_axi = req_q.wdata;
  assign bus.wstrb     = req_q.wstrb;
  assign bus.wlast     = 1'b1;
  assign bus.wvalid    = wvalid_q;
  assign bus.bready    = bready_q;

  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled 1 unit later, mid-cycle.
module tb_sram_axi_bridge;
  import bridge_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  bridge_state_e dbg_state;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            ok_cnt  = 0;

  sram_axi_bridge_if bus_if ();

  sram_axi_bridge #(.BRIDGE_ID(4'd1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // Clock and completion-pulse monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_if.data_ok === 1'b1) ok_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.req       = 1'b0;
    bus_if.wr        = 1'b0;
    bus_if.size      = 2'd0;
    bus_if.addr      = 32'd0;
    bus_if.wdata     = 32'd0;
    bus_if.arready   = 1'b0;
    bus_if.rdata_axi = 32'd0;
    bus_if.rvalid    = 1'b0;
    bus_if.rlast     = 1'b0;
    bus_if.awready   = 1'b0;
    bus_if.wready    = 1'b0;
    bus_if.bvalid    = 1'b0;
  endtask

  // Complete one word read with an immediately responding slave.
  task automatic drive_read(input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] got, output bit to);
    bit seen;
    got = '0; to = 1'b0; seen = 1'b0;
    bus_if.req = 1'b1; bus_if.wr = 1'b0; bus_if.size = 2'd2; bus_if.addr = a;
    #1;
    for (int k = 0; k < 10 && bus_if.addr_ok !== 1'b1; k++) begin
      @(posedge clk); #2;
    end
    if (bus_if.addr_ok !== 1'b1) to = 1'b1;
    @(posedge clk); #1;
    bus_if.req = 1'b0; bus_if.arready = 1'b1;
    #1;
    for (int k = 0; k < 10 && bus_if.arvalid !== 1'b1; k++) begin
      @(posedge clk); #2;
    end
    if (bus_if.arvalid !== 1'b1) to = 1'b1;
    @(posedge clk); #1;
    bus_if.arready = 1'b0; bus_if.rvalid = 1'b1; bus_if.rlast = 1'b1;
    bus_if.rdata_axi = d;
    #1;
    for (int k = 0; k < 10 && bus_if.rready !== 1'b1; k++) begin
      @(posedge clk); #2;
    end
    if (bus_if.data_ok === 1'b1) begin got = bus_if.rdata; seen = 1'b1; end
    @(posedge clk); #1;
    bus_if.rvalid = 1'b0; bus_if.rlast = 1'b0; bus_if.rdata_axi = 32'd0;
    #1;
    if (!seen && bus_if.data_ok === 1'b1) begin got = bus_if.rdata; seen = 1'b1; end
    if (!seen) to = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    #1;
    n_tests++;
    if (dbg_state !== ST_IDLE) begin
      $display("FAIL reset_state: got %0d, expected %0d", dbg_state, ST_IDLE); n_fail++;
    end
    n_tests++;
    if ({bus_if.arvalid, bus_if.rready, bus_if.awvalid, bus_if.wvalid, bus_if.bready,
         bus_if.addr_ok, bus_if.data_ok} !== 7'b0) begin
      $display("FAIL reset_handshakes: got %b, expected 0000000",
               {bus_if.arvalid, bus_if.rready, bus_if.awvalid, bus_if.wvalid, bus_if.bready,
                bus_if.addr_ok, bus_if.data_ok}); n_fail++;
    end
    n_tests++;
    if (bus_if.rdata !== 32'd0) begin
      $display("FAIL reset_rdata: got %h, expected 00000000", bus_if.rdata); n_fail++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_word_read();
    int c0;
    c0 = ok_cnt;
    bus_if.req = 1'b1; bus_if.wr = 1'b0; bus_if.size = 2'd2; bus_if.addr = 32'h1FC0_0000;
    #1;
    n_tests++;
    if (bus_if.addr_ok !== 1'b1) begin
      $display("FAIL rd_accept: got %b, expected 1", bus_if.addr_ok); n_fail++;
    end
    step();
    bus_if.req = 1'b0; bus_if.addr = 32'h0; bus_if.arready = 1'b1;
    #1;
    n_tests++;
    if ({bus_if.arvalid, bus_if.araddr, bus_if.arsize, bus_if.arlen, bus_if.arburst, bus_if.arid}
        !== {1'b1, 32'h1FC0_0000, 3'd2, 4'd0, 2'b01, 4'd1}) begin
      $display("FAIL rd_ar: got v=%b a=%h s=%0d l=%0d b=%b id=%0d, expected v=1 a=1fc00000 s=2 l=0 b=01 id=1",
               bus_if.arvalid, bus_if.araddr, bus_if.arsize, bus_if.arlen, bus_if.arburst,
               bus_if.arid); n_fail++;
    end
    step();
    bus_if.arready = 1'b0; bus_if.rvalid = 1'b1; bus_if.rlast = 1'b1;
    bus_if.rdata_axi = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if ({bus_if.rready, bus_if.arvalid} !== 2'b10) begin
      $display("FAIL rd_rready: got rready=%b arvalid=%b, expected 1 0", bus_if.rready,
               bus_if.arvalid); n_fail++;
    end
`ifndef BRIDGE_RDATA_BUF_EN
    n_tests++;
    if ({bus_if.data_ok, bus_if.rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      $display("FAIL rd_data: got ok=%b d=%h, expected ok=1 d=deadbeef", bus_if.data_ok,
               bus_if.rdata); n_fail++;
    end
`endif
    step();
    bus_if.rvalid = 1'b0; bus_if.rlast = 1'b0; bus_if.rdata_axi = 32'h0;
    #1;
    n_tests++;
    if (dbg_state !== ST_IDLE) begin
      $display("FAIL rd_idle: got %0d, expected %0d", dbg_state, ST_IDLE); n_fail++;
    end
`ifdef BRIDGE_RDATA_BUF_EN
    n_tests++;
    if ({bus_if.data_ok, bus_if.rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      $display("FAIL rd_data: got ok=%b d=%h, expected ok=1 d=deadbeef", bus_if.data_ok,
               bus_if.rdata); n_fail++;
    end
`endif
    step(); step();
    n_tests++;
    if (ok_cnt - c0 !== 1) begin
      $display("FAIL rd_pulses: got %0d, expected 1", ok_cnt - c0); n_fail++;
    end
  endtask

  task automatic test_byte_write();
    int c0;
    c0 = ok_cnt;
    bus_if.req = 1'b1; bus_if.wr = 1'b1; bus_if.size = 2'd0; bus_if.addr = 32'h0000_0103;
    bus_if.wdata = 32'hAA00_0000;
    #1;
    n_tests++;
    if (bus_if.addr_ok !== 1'b1) begin
      $display("FAIL bw_accept: got %b, expected 1", bus_if.addr_ok); n_fail++;
    end
    step();
    idle_inputs(); bus_if.awready = 1'b1;
    #1;
    n_tests++;
    if ({bus_if.awvalid, bus_if.wvalid, bus_if.wstrb, bus_if.awsize, bus_if.awaddr,
         bus_if.wdata_axi} !== {1'b1, 1'b1, 4'b1000, 3'd0, 32'h0000_0103, 32'hAA00_0000}) begin
      $display("FAIL bw_aw_w: got awv=%b wv=%b strb=%b sz=%0d a=%h d=%h, expected 1 1 1000 0 00000103 aa000000",
               bus_if.awvalid, bus_if.wvalid, bus_if.wstrb, bus_if.awsize, bus_if.awaddr,
               bus_if.wdata_axi); n_fail++;
    end
    n_tests++;
    if ({bus_if.awid, bus_if.wid, bus_if.awlen, bus_if.awburst, bus_if.wlast}
        !== {4'd1, 4'd1, 4'd0, 2'b01, 1'b1}) begin
      $display("FAIL bw_const: got awid=%0d wid=%0d len=%0d burst=%b wlast=%b, expected 1 1 0 01 1",
               bus_if.awid, bus_if.wid, bus_if.awlen, bus_if.awburst, bus_if.wlast); n_fail++;
    end
    step();
    bus_if.awready = 1'b0;
    #1;
    n_tests++;
    if ({bus_if.awvalid, bus_if.wvalid, bus_if.bready} !== 3'b010) begin
      $display("FAIL bw_c2: got awv=%b wv=%b bready=%b, expected 0 1 0", bus_if.awvalid,
               bus_if.wvalid, bus_if.bready); n_fail++;
    end
    step();
    bus_if.wready = 1'b1;
    #1;
    n_tests++;
    if ({bus_if.wvalid, bus_if.bready} !== 2'b10) begin
      $display("FAIL bw_c3: got wv=%b bready=%b, expected 1 0", bus_if.wvalid, bus_if.bready);
      n_fail++;
    end
    step();
    bus_if.wready = 1'b0; bus_if.bvalid = 1'b1;
    #1;
    n_tests++;
    if ({bus_if.wvalid, bus_if.bready, bus_if.data_ok} !== 3'b011 || dbg_state !== ST_WR_RESP) begin
      $display("FAIL bw_resp: got wv=%b bready=%b ok=%b st=%0d, expected 0 1 1 %0d", bus_if.wvalid,
               bus_if.bready, bus_if.data_ok, dbg_state, ST_WR_RESP); n_fail++;
    end
    step();
    bus_if.bvalid = 1'b0;
    #1;
    n_tests++;
    if ({bus_if.bready, bus_if.data_ok} !== 2'b00 || dbg_state !== ST_IDLE) begin
      $display("FAIL bw_done: got bready=%b ok=%b st=%0d, expected 0 0 %0d", bus_if.bready,
               bus_if.data_ok, dbg_state, ST_IDLE); n_fail++;
    end
    step();
    n_tests++;
    if (ok_cnt - c0 !== 1) begin
      $display("FAIL bw_pulses: got %0d, expected 1", ok_cnt - c0); n_fail++;
    end
  endtask

  task automatic test_half_write();
    bus_if.req = 1'b1; bus_if.wr = 1'b1; bus_if.size = 2'd1; bus_if.addr = 32'h0000_0002;
    bus_if.wdata = 32'h1234_0000;
    step();
    idle_inputs(); bus_if.awready = 1'b1; bus_if.wready = 1'b1;
    #1;
    n_tests++;
    if ({bus_if.wstrb, bus_if.awsize, bus_if.awvalid, bus_if.wvalid} !== {4'b1100, 3'd1, 2'b11}) begin
      $display("FAIL hw_aw_w: got strb=%b sz=%0d awv=%b wv=%b, expected 1100 1 1 1", bus_if.wstrb,
               bus_if.awsize, bus_if.awvalid, bus_if.wvalid); n_fail++;
    end
    step();
    bus_if.awready = 1'b0; bus_if.wready = 1'b0; bus_if.bvalid = 1'b1;
    #1;
    n_tests++;
    if (dbg_state !== ST_WR_RESP || {bus_if.awvalid, bus_if.wvalid, bus_if.bready, bus_if.data_ok}
        !== 4'b0011) begin
      $display("FAIL hw_resp: got st=%0d awv=%b wv=%b bready=%b ok=%b, expected %0d 0 0 1 1",
               dbg_state, bus_if.awvalid, bus_if.wvalid, bus_if.bready, bus_if.data_ok, ST_WR_RESP);
      n_fail++;
    end
    step();
    bus_if.bvalid = 1'b0;
    step();
  endtask

  task automatic test_ar_stall();
    int c0;
    c0 = ok_cnt;
    bus_if.req = 1'b1; bus_if.wr = 1'b0; bus_if.size = 2'd2; bus_if.addr = 32'h0000_1234;
    step();
    bus_if.addr = 32'h0000_5678;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if ({bus_if.arvalid, bus_if.araddr, bus_if.addr_ok} !== {1'b1, 32'h0000_1234, 1'b0}) begin
        $display("FAIL stall_c%0d: got v=%b a=%h aok=%b, expected 1 00001234 0", i + 1,
                 bus_if.arvalid, bus_if.araddr, bus_if.addr_ok); n_fail++;
      end
      step();
    end
    bus_if.arready = 1'b1;
    #1;
    n_tests++;
    if ({bus_if.arvalid, bus_if.araddr, bus_if.addr_ok} !== {1'b1, 32'h0000_1234, 1'b0}) begin
      $display("FAIL stall_hs: got v=%b a=%h aok=%b, expected 1 00001234 0", bus_if.arvalid,
               bus_if.araddr, bus_if.addr_ok); n_fail++;
    end
    step();
    bus_if.req = 1'b0; bus_if.arready = 1'b0; bus_if.rvalid = 1'b1;
    bus_if.rdata_axi = 32'h0BAD_F00D;
    step();
    bus_if.rvalid = 1'b0; bus_if.rdata_axi = 32'h0;
    step(); step();
    n_tests++;
    if (ok_cnt - c0 !== 1) begin
      $display("FAIL stall_pulses: got %0d, expected 1", ok_cnt - c0); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int          c0;
    logic [31:0] got;
    bit          to;
    c0 = ok_cnt;
    bus_if.req = 1'b1; bus_if.wr = 1'b0; bus_if.size = 2'd2; bus_if.addr = 32'h0000_0080;
    step();
    bus_if.req = 1'b0; bus_if.arready = 1'b1;
    step();
    bus_if.arready = 1'b0;
    #1;
    n_tests++;
    if (dbg_state !== ST_RD_DATA || bus_if.rready !== 1'b1) begin
      $display("FAIL rstmid_pre: got st=%0d rready=%b, expected %0d 1", dbg_state, bus_if.rready,
               ST_RD_DATA); n_fail++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_tests++;
    if (dbg_state !== ST_IDLE || {bus_if.rready, bus_if.arvalid, bus_if.data_ok} !== 3'b000) begin
      $display("FAIL rstmid_post: got st=%0d rready=%b arv=%b ok=%b, expected %0d 0 0 0",
               dbg_state, bus_if.rready, bus_if.arvalid, bus_if.data_ok, ST_IDLE); n_fail++;
    end
    step();
    n_tests++;
    if (ok_cnt !== c0) begin
      $display("FAIL rstmid_nopulse: got %0d, expected %0d", ok_cnt, c0); n_fail++;
    end
    drive_read(32'h0000_0040, 32'h5A5A_1234, got, to);
    n_tests++;
    if (to !== 1'b0 || got !== 32'h5A5A_1234) begin
      $display("FAIL rstmid_read: got to=%b d=%h, expected 0 5a5a1234", to, got); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = ok_cnt;
    bus_if.req = 1'b1; bus_if.wr = 1'b0; bus_if.size = 2'd2; bus_if.addr = 32'h0000_0100;
    step();
    bus_if.wr = 1'b1; bus_if.addr = 32'h0000_0204; bus_if.wdata = 32'hCAFE_F00D;
    bus_if.arready = 1'b1;
    #1;
    n_tests++;
    if (bus_if.addr_ok !== 1'b0) begin
      $display("FAIL b2b_c1: got aok=%b, expected 0", bus_if.addr_ok); n_fail++;
    end
    step();
    bus_if.arready = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata_axi = 32'h1111_2222;
    #1;
`ifdef BRIDGE_RDATA_BUF_EN
    n_tests++;
    if ({bus_if.data_ok, bus_if.addr_ok} !== 2'b00) begin
      $display("FAIL b2b_c2: got ok=%b aok=%b, expected 0 0", bus_if.data_ok, bus_if.addr_ok);
      n_fail++;
    end
`else
    n_tests++;
    if ({bus_if.data_ok, bus_if.addr_ok, bus_if.rdata} !== {2'b10, 32'h1111_2222}) begin
      $display("FAIL b2b_c2: got ok=%b aok=%b d=%h, expected 1 0 11112222", bus_if.data_ok,
               bus_if.addr_ok, bus_if.rdata); n_fail++;
    end
`endif
    step();
    bus_if.rvalid = 1'b0; bus_if.rdata_axi = 32'h0;
    #1;
`ifdef BRIDGE_RDATA_BUF_EN
    n_tests++;
    if ({bus_if.data_ok, bus_if.addr_ok, bus_if.rdata} !== {2'b11, 32'h1111_2222}) begin
      $display("FAIL b2b_c3: got ok=%b aok=%b d=%h, expected 1 1 11112222", bus_if.data_ok,
               bus_if.addr_ok, bus_if.rdata); n_fail++;
    end
`else
    n_tests++;
    if ({bus_if.data_ok, bus_if.addr_ok} !== 2'b01) begin
      $display("FAIL b2b_c3: got ok=%b aok=%b, expected 0 1", bus_if.data_ok, bus_if.addr_ok);
      n_fail++;
    end
`endif
    step();
    idle_inputs(); bus_if.awready = 1'b1; bus_if.wready = 1'b1;
    #1;
    n_tests++;
    if ({bus_if.awvalid, bus_if.wvalid, bus_if.awaddr, bus_if.wdata_axi, bus_if.wstrb, bus_if.data_ok}
        !== {2'b11, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 1'b0}) begin
      $display("FAIL b2b_c4: got awv=%b wv=%b a=%h d=%h strb=%b ok=%b, expected 1 1 00000204 cafef00d 1111 0",
               bus_if.awvalid, bus_if.wvalid, bus_if.awaddr, bus_if.wdata_axi, bus_if.wstrb,
               bus_if.data_ok); n_fail++;
    end
    step();
    bus_if.awready = 1'b0; bus_if.wready = 1'b0; bus_if.bvalid = 1'b1;
    #1;
    n_tests++;
    if ({bus_if.bready, bus_if.data_ok} !== 2'b11) begin
      $display("FAIL b2b_c5: got bready=%b ok=%b, expected 1 1", bus_if.bready, bus_if.data_ok);
      n_fail++;
    end
    step();
    bus_if.bvalid = 1'b0;
    step(); step();
    n_tests++;
    if (ok_cnt - c0 !== 2) begin
      $display("FAIL b2b_pulses: got %0d, expected 2", ok_cnt - c0); n_fail++;
    end
  endtask

  // Test sequence and final report
  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_word_read();
    test_byte_write();
    test_half_write();
    test_ar_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
